// File: rtl/debug_pkg.sv
// Shared types for the debug dump sequencer: FSM state encoding, frame
// sections and the default frame length.
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PC,
        CLK,
        RB,
        DM,
        CSUM
    } section_t;

    // PC + clock count + 32 registers + 16 data-memory words.
    localparam int DEFAULT_FRAME_WORDS = 2 + 32 + 16;

    function automatic int frame_words(input int bank_size, input int dm_words,
                                       input int csum_words);
        return 2 + bank_size + dm_words + csum_words;
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Read bus (register bank, data memory) and UART transmit handshake of the
// debug dump sequencer. master = sequencer side, slave = memories/UART side.
interface debug_dump_sequencer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int RBITS          = 5,
    parameter int DM_ADDR_LENGTH = 32
);
    logic [RBITS-1:0]          RB_Addr;
    logic [DATA_WIDTH-1:0]     RB_Data;
    logic [DM_ADDR_LENGTH-1:0] DM_Addr;
    logic [DATA_WIDTH-1:0]     DM_Data;
    logic [DATA_WIDTH-1:0]     tx_Data;
    logic                      tx_start;
    logic                      tx_done;

    modport master (
        output RB_Addr, DM_Addr, tx_Data, tx_start,
        input  RB_Data, DM_Data, tx_done
    );

    modport slave (
        input  RB_Addr, DM_Addr, tx_Data, tx_start,
        output RB_Data, DM_Data, tx_done
    );
endinterface

// File: rtl/dump_addr_counter.sv
// Word index of the dump frame, decoded into the frame section and the
// register-bank / data-memory read addresses.
module dump_addr_counter
    import debug_pkg::*;
#(
    parameter int RBITS          = 5,
    parameter int BANK_SIZE      = 32,
    parameter int DM_ADDR_LENGTH = 32,
    parameter int DM_DUMP_WORDS  = 16,
    parameter int IDX_W          = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      advance,
    output logic [IDX_W-1:0]          index,
    output section_t                  section,
    output logic [RBITS-1:0]          rb_addr,
    output logic [DM_ADDR_LENGTH-1:0] dm_addr
);
    localparam logic [IDX_W-1:0] RB_BASE   = IDX_W'(2);
    localparam logic [IDX_W-1:0] DM_BASE   = IDX_W'(2 + BANK_SIZE);
    localparam logic [IDX_W-1:0] CSUM_BASE = IDX_W'(2 + BANK_SIZE + DM_DUMP_WORDS);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every reader sees the pre-edge value regardless of process order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            index <= '0;
        end else if (advance) begin
            index <= index + IDX_W'(1);
        end
    end

    // With DM_DUMP_WORDS = 0 the DM range is empty, so RB runs straight into
    // the end of the frame (or the checksum word).
    always_comb begin
        section = CSUM;
        if (index == '0) begin
            section = PC;
        end else if (index == IDX_W'(1)) begin
            section = CLK;
        end else if (index < DM_BASE) begin
            section = RB;
        end else if (index < CSUM_BASE) begin
            section = DM;
        end
    end

    assign rb_addr = (section == RB) ? RBITS'(index - RB_BASE) : '0;
    assign dm_addr = (section == DM) ? DM_ADDR_LENGTH'(index - DM_BASE) : '0;

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, clock count, the register bank and a data-memory window out
// through a word-wide UART handshake. Optional trailing XOR word: DUMP_CHECKSUM_EN.
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int RBITS          = 5,
    parameter int BANK_SIZE      = 32,
    parameter int DM_ADDR_LENGTH = 32,
    parameter int DM_DUMP_WORDS  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dump_start,
    input  logic [DATA_WIDTH-1:0]  current_pc,
    input  logic [DATA_WIDTH-1:0]  clock_count,
    debug_dump_sequencer_if.master bus,
    output logic                   busy,
    output logic                   dump_done
);
`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif
    localparam int FRAME_WORDS = frame_words(BANK_SIZE, DM_DUMP_WORDS, CSUM_WORDS);
    // One spare code so the index never wraps even if stepped past the end.
    localparam int IDX_W = $clog2(FRAME_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    state_t                state, state_next;
    section_t              section;
    logic [IDX_W-1:0]      index;
    logic                  last;
    logic                  idx_clear;
    logic                  idx_advance;
    logic [DATA_WIDTH-1:0] word_sel;

    dump_addr_counter #(
        .RBITS          (RBITS),
        .BANK_SIZE      (BANK_SIZE),
        .DM_ADDR_LENGTH (DM_ADDR_LENGTH),
        .DM_DUMP_WORDS  (DM_DUMP_WORDS),
        .IDX_W          (IDX_W)
    ) u_addr_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (idx_clear),
        .advance (idx_advance),
        .index   (index),
        .section (section),
        .rb_addr (bus.RB_Addr),
        .dm_addr (bus.DM_Addr)
    );

    assign last = (index == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        idx_clear   = 1'b0;
        idx_advance = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = LOAD;
                    idx_clear  = 1'b1;
                end
            end
            LOAD:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        state_next  = LOAD;
                        idx_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_clear  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && dump_start)) begin
            csum <= '0;
        end else if (state == SEND && section != CSUM) begin
            csum <= csum ^ word_sel;
        end
    end
`endif

    always_comb begin
        word_sel = '0;
        case (section)
            PC:  word_sel = current_pc;
            CLK: word_sel = clock_count;
            RB:  word_sel = bus.RB_Data;
            DM:  word_sel = bus.DM_Data;
            default: begin
`ifdef DUMP_CHECKSUM_EN
                word_sel = csum;
`endif
            end
        endcase
    end

    // Word and strobe leave SEND together, so tx_Data is already valid
    // while tx_start is high and stays put for the whole WAIT_TX.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_Data  <= '0;
            bus.tx_start <= 1'b0;
        end else begin
            bus.tx_start <= (state == SEND);
            if (state == SEND) begin
                bus.tx_Data <= word_sel;
            end
        end
    end

    assign busy      = (state == LOAD) || (state == SEND) || (state == WAIT_TX);
    assign dump_done = (state == DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench: random register/memory contents, frames compared
// against an expected word list built from the frame-order rules.
`timescale 1ns/1ps
module tb_debug_dump_sequencer;

    localparam int DW   = 32;
    localparam int RBW  = 5;
    localparam int BANK = 32;
    localparam int DML  = 32;
    localparam int DMW  = 16;
`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          td = 1'b0;
    logic          sel = 1'b0;
    logic [DW-1:0] current_pc = '0;
    logic [DW-1:0] clock_count = '0;
    logic          busy_a, done_a, busy_b, done_b;

    debug_dump_sequencer_if #(.DATA_WIDTH(DW), .RBITS(RBW), .DM_ADDR_LENGTH(DML)) bus_a ();
    debug_dump_sequencer_if #(.DATA_WIDTH(DW), .RBITS(RBW), .DM_ADDR_LENGTH(DML)) bus_b ();

    debug_dump_sequencer #(
        .DATA_WIDTH(DW), .RBITS(RBW), .BANK_SIZE(BANK), .DM_ADDR_LENGTH(DML), .DM_DUMP_WORDS(DMW)
    ) dut_a (
        .clk(clk), .rst(rst), .dump_start(start & ~sel), .current_pc(current_pc),
        .clock_count(clock_count), .bus(bus_a), .busy(busy_a), .dump_done(done_a)
    );

    debug_dump_sequencer #(
        .DATA_WIDTH(DW), .RBITS(RBW), .BANK_SIZE(BANK), .DM_ADDR_LENGTH(DML), .DM_DUMP_WORDS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .dump_start(start & sel), .current_pc(current_pc),
        .clock_count(clock_count), .bus(bus_b), .busy(busy_b), .dump_done(done_b)
    );

    always #5 clk = ~clk;

    assign bus_a.tx_done = td & ~sel;
    assign bus_b.tx_done = td & sel;

    // Register bank and data memory with one-cycle read latency.
    logic [DW-1:0] rb_mem [BANK];
    logic [DW-1:0] dm_mem [DMW];
    always @(posedge clk) begin
        bus_a.RB_Data <= rb_mem[bus_a.RB_Addr];
        bus_a.DM_Data <= dm_mem[bus_a.DM_Addr[3:0]];
        bus_b.RB_Data <= rb_mem[bus_b.RB_Addr];
        bus_b.DM_Data <= 32'hDEAD_BEEF;
    end

    logic          tx_start_s, busy_s, done_s;
    logic [DW-1:0] tx_data_s;
    logic [RBW-1:0] rb_addr_s;
    logic [DML-1:0] dm_addr_s;
    assign tx_start_s = sel ? bus_b.tx_start : bus_a.tx_start;
    assign tx_data_s  = sel ? bus_b.tx_Data  : bus_a.tx_Data;
    assign busy_s     = sel ? busy_b : busy_a;
    assign done_s     = sel ? done_b : done_a;
    assign rb_addr_s  = sel ? bus_b.RB_Addr : bus_a.RB_Addr;
    assign dm_addr_s  = sel ? bus_b.DM_Addr : bus_a.DM_Addr;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pc_new, cnt_new;
    int   done_pulses, unstable, busy_bad, dm_nonzero;
    logic busy_at_done;
    bit   aborted, timed_out;
    logic [2:0]    snap_ctrl;
    logic [DW-1:0] snap_data;
    logic [RBW+DML-1:0] snap_addr;

    function automatic void randomize_contents(input bit zero);
        for (int i = 0; i < BANK; i++) rb_mem[i] = zero ? '0 : $urandom;
        for (int i = 0; i < DMW; i++)  dm_mem[i] = zero ? '0 : $urandom;
        current_pc  = $urandom;
        clock_count = $urandom;
        pc_new  = current_pc ^ ($urandom | 32'd1);
        cnt_new = clock_count ^ ($urandom | 32'd1);
    endfunction

    // Frame = PC, clock count, RB[0..BANK-1], DM[0..dm_words-1], optional XOR of all.
    function automatic void build_expected(input int dm_words);
        logic [DW-1:0] x;
        exp_q.delete();
        exp_q.push_back(pc_new);
        exp_q.push_back(cnt_new);
        for (int i = 0; i < BANK; i++) exp_q.push_back(rb_mem[i]);
        for (int i = 0; i < dm_words; i++) exp_q.push_back(dm_mem[i]);
        if (CSUM_WORDS == 1) begin
            x = '0;
            foreach (exp_q[i]) x ^= exp_q[i];
            exp_q.push_back(x);
        end
    endfunction

    // Requests a frame and acts as the UART: tx_done pulsed 2-3 cycles after
    // each tx_start. Optional dump_start poke or rst in WAIT_TX of one word.
    task automatic run_frame(input int poke_word, input int abort_word, input bit hold_done);
        int cyc = 0;
        int wait_cnt = -1;
        int post = 0;
        bit done_seen = 0;
        logic [DW-1:0] held = '0;
        got.delete();
        done_pulses = 0; unstable = 0; busy_bad = 0; dm_nonzero = 0;
        busy_at_done = 1'b0; aborted = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1;
        td = hold_done;
        @(negedge clk);
        start = 1'b0;
        current_pc = pc_new;
        while (cyc < 4000 && post < 8 && !aborted) begin
            cyc++;
            if (done_seen) post++;
            if (done_s) begin
                done_pulses++;
                done_seen = 1;
                busy_at_done = busy_s;
            end
            if (sel && dm_addr_s != '0) dm_nonzero++;
            if (tx_start_s) begin
                got.push_back(tx_data_s);
                held = tx_data_s;
                wait_cnt = 0;
                td = 1'b0;
                if (!busy_s) busy_bad++;
                if (got.size() == 1) clock_count = cnt_new;
            end else if (wait_cnt >= 0) begin
                wait_cnt++;
                if (wait_cnt == 2 && rst) begin
                    snap_ctrl = {tx_start_s, busy_s, done_s};
                    snap_data = tx_data_s;
                    snap_addr = {rb_addr_s, dm_addr_s};
                    rst = 1'b0;
                    aborted = 1;
                end else begin
                    if (tx_data_s !== held) unstable++;
                    if (wait_cnt == 1 && got.size() - 1 == poke_word) start = 1'b1;
                    if (wait_cnt == 1 && got.size() - 1 == abort_word) rst = 1'b1;
                    if (wait_cnt == 2) begin
                        start = 1'b0;
                        td = 1'b1;
                    end
                    if (wait_cnt == 3) begin
                        td = 1'b0;
                        wait_cnt = -1;
                    end
                end
            end
            if (!aborted) @(negedge clk);
        end
        if (!done_seen && !aborted) timed_out = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; td = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0; td = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            vectors++;
            if ({tx_start_s, busy_s, done_s} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_ctrl dut%0d: tx_start/busy/done=%b expected 000", s, {tx_start_s, busy_s, done_s});
            end
            vectors++;
            if (tx_data_s !== '0) begin
                miscompares++;
                $display("FAIL reset_tx_data dut%0d: got %h expected 0", s, tx_data_s);
            end
            vectors++;
            if (rb_addr_s !== '0 || dm_addr_s !== '0) begin
                miscompares++;
                $display("FAIL reset_addr dut%0d: RB_Addr=%h DM_Addr=%h expected 0", s, rb_addr_s, dm_addr_s);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_override_start: busy_a=%b busy_b=%b expected 0", busy_a, busy_b);
        end
    endtask

    task automatic test_full_frame(input string name, input bit zero, input int poke_word,
                                   input bit hold_done);
        int mism = 0;
        sel = 1'b0;
        randomize_contents(zero);
        if (zero) begin
            pc_new  = 32'h10;
            cnt_new = 32'h5;
        end
        build_expected(DMW);
        run_frame(poke_word, -1, hold_done);
        vectors++;
        if (timed_out || got.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_len: got %0d words (timeout=%0d) expected %0d", name, got.size(), timed_out, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                mism++;
                if (mism < 5) $display("FAIL %s_word%0d: got %h expected %h", name, i, got[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_pulses != 1 || busy_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: dump_done pulses=%0d busy_at_done=%b expected 1 and 0", name, done_pulses, busy_at_done);
        end
        vectors++;
        if (unstable != 0 || busy_bad != 0) begin
            miscompares++;
            $display("FAIL %s_hold: tx_Data changes=%0d strobes without busy=%0d expected 0", name, unstable, busy_bad);
        end
    endtask

    task automatic test_checksum_zero();
        test_full_frame("csum", 1'b1, -1, 1'b0);
        vectors++;
        if (got.size() == 0 || got[got.size() - 1] !== (CSUM_WORDS == 1 ? 32'h15 : 32'h0)) begin
            miscompares++;
            $display("FAIL csum_last: got %h expected %h", got.size() ? got[got.size() - 1] : 32'hx,
                     CSUM_WORDS == 1 ? 32'h15 : 32'h0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int stray = 0;
        sel = 1'b0;
        randomize_contents(1'b0);
        build_expected(DMW);
        run_frame(-1, 20, 1'b0);
        vectors++;
        if (!aborted || got.size() != 21) begin
            miscompares++;
            $display("FAIL abort_reach: aborted=%0d words=%0d expected 1 and 21", aborted, got.size());
        end
        vectors++;
        if (snap_ctrl !== 3'b000 || snap_data !== '0 || snap_addr !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: ctrl=%b data=%h addr=%h expected all 0", snap_ctrl, snap_data, snap_addr);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start_s || busy_s) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: %0d cycles with tx_start/busy expected 0", stray);
        end
        test_full_frame("after_abort", 1'b0, -1, 1'b0);
    endtask

    task automatic test_no_dm();
        int mism = 0;
        sel = 1'b1;
        randomize_contents(1'b0);
        build_expected(0);
        run_frame(-1, -1, 1'b0);
        vectors++;
        if (timed_out || got.size() != 34 + CSUM_WORDS) begin
            miscompares++;
            $display("FAIL nodm_len: got %0d words (timeout=%0d) expected %0d", got.size(), timed_out, 34 + CSUM_WORDS);
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== exp_q[i]) begin
                miscompares++;
                mism++;
                if (mism < 5) $display("FAIL nodm_word%0d: got %h expected %h", i, got[i], exp_q[i]);
            end
        end
        vectors++;
        if (dm_nonzero != 0 || done_pulses != 1) begin
            miscompares++;
            $display("FAIL nodm_addr_done: DM_Addr nonzero cycles=%0d done pulses=%0d expected 0 and 1", dm_nonzero, done_pulses);
        end
        sel = 1'b0;
    endtask

    task automatic test_tx_done_ignored();
        int stray = 0;
        sel = 1'b0;
        @(negedge clk);
        td = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_start_s || busy_s || done_s) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL idle_tx_done: %0d active cycles expected 0", stray);
        end
        test_full_frame("txdone_early", 1'b0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_frame("frame", 1'b0, -1, 1'b0);
        test_checksum_zero();
        test_full_frame("restart_ignored", 1'b0, 7, 1'b0);
        test_reset_mid_frame();
        test_no_dm();
        test_tx_done_ignored();
        test_full_frame("back_to_back", 1'b0, -1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
